stage_memory: RTL

- Pipeline stage directly downstream of the execute stage; consumes its registered mem_* outputs.
- Performs data-memory loads/stores over a req/ack bus and resolves branches/jumps into a redirect.
- Detects misalignment and bus errors.
- Presents registered results to the writeback stage; drives mem_stall back to execute.

---
 rtl/stage_memory_pkg.sv | 36 +++
 rtl/stage_memory_mem_align.sv | 58 +++++
 rtl/stage_memory.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/stage_memory_pkg.sv
// Shared definitions for the memory pipeline stage: access widths,
// exception causes, FSM states and the alignment rule.
package stage_memory_pkg;

    // Access width encodings carried on mem_width (3 is treated as word).
    localparam logic [1:0] MEMW_BYTE = 2'd0;
    localparam logic [1:0] MEMW_HALF = 2'd1;
    localparam logic [1:0] MEMW_WORD = 2'd2;

    // Exception cause encodings reported on exc_cause.
    localparam logic [1:0] EXC_LOAD_MISALIGN   = 2'd0;
    localparam logic [1:0] EXC_STORE_MISALIGN  = 2'd1;
    localparam logic [1:0] EXC_TARGET_MISALIGN = 2'd2;
    localparam logic [1:0] EXC_BUS_ERR         = 2'd3;

    // Bus transfer state: either free or waiting for dmem_ack.
    typedef enum logic {
        MST_IDLE = 1'b0,
        MST_BUSY = 1'b1
    } mem_state_t;

    // A half access needs an even address, a word (or the reserved
    // width) needs both low bits clear; bytes are always aligned.
    function automatic logic is_misaligned(input logic [1:0] width,
                                           input logic [1:0] addr_lo);
        logic result;
        result = 1'b0;
        case (width)
            MEMW_BYTE: result = 1'b0;
            MEMW_HALF: result = addr_lo[0];
            default:   result = |addr_lo;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/stage_memory_mem_align.sv
// Combinational byte-lane logic: store data replication and strobes,
// load lane extraction with sign/zero extension, and the misalign flag.
module mem_align
    import stage_memory_pkg::*;
#(
    parameter int CHECK_ALIGN = 1
) (
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_width,
    input  logic        i_extend,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_load_data,
    output logic        o_misaligned
);

    logic [31:0] w_shifted;

    // Misalignment is only reported when alignment checking is enabled;
    // otherwise the low address bits are used as-is by the lane logic.
    assign o_misaligned = (CHECK_ALIGN != 0) && is_misaligned(i_width, i_addr_lo);

    // The addressed byte is moved down to bit 0 before truncation.
    assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

    // Replicate store data across all lanes and select lanes by strobe.
    always_comb begin
        o_wdata = i_store_data;
        o_wstrb = 4'b1111;
        case (i_width)
            MEMW_BYTE: begin
                o_wdata = {4{i_store_data[7:0]}};
                o_wstrb = 4'b0001 << i_addr_lo;
            end
            MEMW_HALF: begin
                o_wdata = {2{i_store_data[15:0]}};
                o_wstrb = 4'b0011 << i_addr_lo;
            end
            default: begin
                o_wdata = i_store_data;
                o_wstrb = 4'b1111;
            end
        endcase
    end

    // Truncate the shifted read data to the access width and extend.
    always_comb begin
        o_load_data = w_shifted;
        case (i_width)
            MEMW_BYTE: o_load_data = {{24{i_extend & w_shifted[7]}}, w_shifted[7:0]};
            MEMW_HALF: o_load_data = {{16{i_extend & w_shifted[15]}}, w_shifted[15:0]};
            default:   o_load_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/stage_memory.sv
// Memory pipeline stage: issues data-memory transfers over a req/ack bus,
// resolves branches and jumps into a redirect, raises misalignment and
// bus-error exceptions, and presents registered results to writeback.
module stage_memory
    import stage_memory_pkg::*;
#(
    parameter int CHECK_ALIGN = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic [31:0] mem_data0,
    input  logic [31:0] mem_data1,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_extend,
    input  logic [1:0]  mem_width,
    input  logic        mem_jmp,
    input  logic        mem_br,
    input  logic        mem_br_inv,
    input  logic [4:0]  wb_reg,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_err,
    output logic        br_taken,
    output logic [31:0] br_target,
    output logic        wb_valid,
    output logic [4:0]  wb_reg_r,
    output logic [31:0] wb_data,
    output logic        exc_valid,
    output logic [1:0]  exc_cause,
    output logic [31:0] exc_pc
);

    mem_state_t  r_state;
    mem_state_t  r_state_next;

    // Context of the outstanding transfer, captured when it is issued.
    logic        r_is_load;
    logic [1:0]  r_addr_lo;
    logic [1:0]  r_width;
    logic        r_extend;
    logic [31:0] r_pc;
    logic [4:0]  r_rd;

    logic        w_access;
    logic        w_misaligned;
    logic        w_taken;
    logic        w_target_mis;
    logic        w_issue;
    logic        w_ack_done;
    logic        w_misalign_exc;
    logic        w_retire;
    logic [1:0]  w_align_lo;
    logic [1:0]  w_align_width;
    logic        w_align_extend;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic [31:0] w_load_data;

    assign w_access     = mem_valid & (mem_read | mem_write);
    assign w_taken      = mem_jmp | (mem_br & (mem_data0[0] ^ mem_br_inv));
    assign w_target_mis = (CHECK_ALIGN != 0) && (mem_data1[1:0] != 2'b00);

    // While idle the lane logic looks at the incoming instruction; while
    // busy it uses the captured context so the load result does not depend
    // on execute holding its registers.
    assign w_align_lo     = (r_state == MST_BUSY) ? r_addr_lo : mem_data0[1:0];
    assign w_align_width  = (r_state == MST_BUSY) ? r_width   : mem_width;
    assign w_align_extend = (r_state == MST_BUSY) ? r_extend  : mem_extend;

    mem_align #(
        .CHECK_ALIGN (CHECK_ALIGN)
    ) u_align (
        .i_addr_lo    (w_align_lo),
        .i_width      (w_align_width),
        .i_extend     (w_align_extend),
        .i_store_data (mem_data1),
        .i_rdata      (dmem_rdata),
        .o_wdata      (w_wdata),
        .o_wstrb      (w_wstrb),
        .o_load_data  (w_load_data),
        .o_misaligned (w_misaligned)
    );

    // State register; reset abandons any transfer in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= MST_IDLE;
        end else begin
            r_state <= r_state_next;
        end
    end

    // Next state, stall back to execute and the per-cycle action strobes.
    always_comb begin
        r_state_next   = r_state;
        mem_stall      = 1'b0;
        w_issue        = 1'b0;
        w_ack_done     = 1'b0;
        w_misalign_exc = 1'b0;
        w_retire       = 1'b0;
        case (r_state)
            MST_IDLE: begin
                if (w_access) begin
                    if (w_misaligned) begin
                        w_misalign_exc = 1'b1;
                    end else begin
                        w_issue      = 1'b1;
                        mem_stall    = 1'b1;
                        r_state_next = MST_BUSY;
                    end
                end else if (mem_valid) begin
                    w_retire = 1'b1;
                end
            end
            MST_BUSY: begin
                if (dmem_ack) begin
                    w_ack_done   = 1'b1;
                    r_state_next = MST_IDLE;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: r_state_next = MST_IDLE;
        endcase
    end

    // Bus request registers and transfer context; held stable while busy.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_wdata <= 32'd0;
            dmem_wstrb <= 4'd0;
            r_is_load  <= 1'b0;
            r_addr_lo  <= 2'd0;
            r_width    <= 2'd0;
            r_extend   <= 1'b0;
            r_pc       <= 32'd0;
            r_rd       <= 5'd0;
        end else if (w_issue) begin
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write;
            dmem_addr  <= {mem_data0[31:2], 2'b00};
            dmem_wdata <= w_wdata;
            dmem_wstrb <= mem_write ? w_wstrb : 4'b0000;
            r_is_load  <= mem_read;
            r_addr_lo  <= mem_data0[1:0];
            r_width    <= mem_width;
            r_extend   <= mem_extend;
            r_pc       <= mem_pc;
            r_rd       <= wb_reg;
        end else if (w_ack_done) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
        end
    end

    // Writeback, redirect and exception outputs; the valid flags are
    // single-cycle pulses that drop unless something retires again.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            br_taken  <= 1'b0;
            br_target <= 32'd0;
            wb_valid  <= 1'b0;
            wb_reg_r  <= 5'd0;
            wb_data   <= 32'd0;
            exc_valid <= 1'b0;
            exc_cause <= 2'd0;
            exc_pc    <= 32'd0;
        end else begin
            br_taken  <= 1'b0;
            wb_valid  <= 1'b0;
            exc_valid <= 1'b0;
            if (w_ack_done) begin
                if (dmem_err) begin
                    exc_valid <= 1'b1;
                    exc_cause <= EXC_BUS_ERR;
                    exc_pc    <= r_pc;
                end else if (r_is_load) begin
                    wb_valid <= 1'b1;
                    wb_data  <= w_load_data;
                    wb_reg_r <= r_rd;
                end
            end
            if (w_misalign_exc) begin
                exc_valid <= 1'b1;
                exc_cause <= mem_read ? EXC_LOAD_MISALIGN : EXC_STORE_MISALIGN;
                exc_pc    <= mem_pc;
            end
            if (w_retire) begin
                if (w_taken && w_target_mis) begin
                    // A bad target is reported instead of redirecting, and
                    // the instruction produces no writeback.
                    exc_valid <= 1'b1;
                    exc_cause <= EXC_TARGET_MISALIGN;
                    exc_pc    <= mem_pc;
                end else begin
                    wb_valid <= ~mem_br;
                    wb_data  <= mem_data0;
                    wb_reg_r <= wb_reg;
                    if (w_taken) begin
                        br_taken  <= 1'b1;
                        br_target <= mem_data1;
                    end
                end
            end
        end
    end

endmodule
